// File: rtl/mmio_responder.sv
// ---------------------------------------------------------------------------
// mmio_responder
//
// Memory-mapped register window on the CPU data-memory bus. It decodes a
// 64-byte window at BASE_ADDR and serves 64-bit loads and stores to it.
//
// Registers (offset = addr[5:3]):
//   0 CYCLE     RO  clocks since reset (only with MMIO_CYCLE_CNT_EN, else 0)
//   1 SCRATCH   RW  64-bit scratch
//   2 TX_DATA   store pushes mem_data[7:0]; load returns FIFO count
//   3 TX_STATUS bit0 empty, bit1 full, bit2 overflow (sticky),
//               bits[12:8] count; store with bit2=1 clears overflow
//   4 HALT      store nonzero sets halt_req (sticky until reset)
//   5..7        reserved, read 0, writes ignored
//
// Ports:
//   clk       single clock, rising edge
//   rst       asynchronous active-high reset
//   mem_data  bidirectional CPU data bus, driven only on a window load
//   mem_rw    1 = store, 0 = load
//   addr      byte address, bits [2:0] ignored
//   mmio_hit  combinational window decode
//   tx_data   registered FIFO head byte
//   tx_valid  registered FIFO non-empty
//   tx_ready  consumer accepts head this cycle
//   halt_req  sticky halt request
//
// Build option: define MMIO_CYCLE_CNT_EN to include the CYCLE counter.
// ---------------------------------------------------------------------------
module mmio_responder #(
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_0001_0000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [63:0] mem_data,
    input  logic        mem_rw,
    input  logic [63:0] addr,
    output logic        mmio_hit,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt_req
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [2:0] OFF_CYCLE     = 3'd0;
    localparam logic [2:0] OFF_SCRATCH   = 3'd1;
    localparam logic [2:0] OFF_TX_DATA   = 3'd2;
    localparam logic [2:0] OFF_TX_STATUS = 3'd3;
    localparam logic [2:0] OFF_HALT      = 3'd4;

    logic [2:0]       reg_off;
    logic             wr_en;
    logic             push_req;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic [63:0]      rdata;
    logic [63:0]      cycle_val;
    logic             unused_addr_bits;

    logic [7:0]       fifo_q [FIFO_DEPTH];
    logic [7:0]       fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic [63:0]      scratch_q, scratch_d;
    logic             halt_q, halt_d;

    assign mmio_hit         = (addr[63:6] == BASE_ADDR[63:6]);
    assign reg_off          = addr[5:3];
    assign wr_en            = mmio_hit && mem_rw;
    assign unused_addr_bits = ^addr[2:0];

    // ---------------- CYCLE counter (optional) ----------------
`ifdef MMIO_CYCLE_CNT_EN
    logic [63:0] cycle_q, cycle_d;

    always_comb begin
        cycle_d = cycle_q + 64'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_val = cycle_q;
`else
    assign cycle_val = '0;
`endif

    // ---------------- Next-state logic ----------------
    always_comb begin
        push_req   = wr_en && (reg_off == OFF_TX_DATA);
        pop        = tx_valid_q && tx_ready;
        full       = (count_q == FULL_CNT);
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push_ok    = push_req && (!full || pop);

        fifo_d     = fifo_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;

        if (push_ok) begin
            fifo_d[wr_ptr_q] = mem_data[7:0];
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (push_req && full && !pop) begin
            ovf_d = 1'b1;
        end
        if (wr_en && (reg_off == OFF_TX_STATUS) && mem_data[2]) begin
            ovf_d = 1'b0;
        end

        // Head is taken from the post-update storage so a push into an
        // empty FIFO shows up on tx_data in the very next cycle.
        tx_valid_d = (count_d != '0);
        tx_data_d  = tx_valid_d ? fifo_d[rd_ptr_d] : tx_data_q;

        scratch_d  = (wr_en && (reg_off == OFF_SCRATCH)) ? mem_data : scratch_q;
        halt_d     = halt_q | (wr_en && (reg_off == OFF_HALT) && (mem_data != '0));
    end

    // ---------------- State registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q     <= '{default: '0};
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            scratch_q  <= '0;
            halt_q     <= 1'b0;
        end else begin
            fifo_q     <= fifo_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            scratch_q  <= scratch_d;
            halt_q     <= halt_d;
        end
    end

    // ---------------- Load path ----------------
    always_comb begin
        case (reg_off)
            OFF_CYCLE:     rdata = cycle_val;
            OFF_SCRATCH:   rdata = scratch_q;
            OFF_TX_DATA:   rdata = 64'(count_q);
            OFF_TX_STATUS: rdata = {51'd0, 5'(count_q), 5'd0, ovf_q, full, (count_q == '0)};
            OFF_HALT:      rdata = {63'd0, halt_q};
            default:       rdata = '0;
        endcase
    end

    assign mem_data = (mmio_hit && !mem_rw) ? rdata : 64'bz;

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign halt_req = halt_q;

endmodule

// File: tb/tb_mmio_responder.sv
module tb_mmio_responder;

    localparam logic [63:0] BASE  = 64'h0000_0000_0001_0000;
    localparam int          DEPTH = 8;
`ifdef MMIO_CYCLE_CNT_EN
    localparam logic [63:0] EXP10  = 64'd10;
    localparam logic [63:0] EXP100 = 64'd100;
`else
    localparam logic [63:0] EXP10  = 64'd0;
    localparam logic [63:0] EXP100 = 64'd0;
`endif
    // Undriven bus floats to all ones through the pullups.
    localparam logic [63:0] BUS_FREE = {64{1'b1}};

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        mem_rw   = 1'b0;
    logic        tx_ready = 1'b0;
    logic        drv      = 1'b0;
    logic [63:0] addr     = BASE + 64'h28;
    logic [63:0] wdat     = '0;
    wire  [63:0] mem_data;
    wire         mmio_hit;
    wire  [7:0]  tx_data;
    wire         tx_valid;
    wire         halt_req;

    assign mem_data = drv ? wdat : 64'bz;

    for (genvar gi = 0; gi < 64; gi++) begin : g_pu
        pullup pu (mem_data[gi]);
    end

    always #5 clk = ~clk;

    mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_data (mem_data),
        .mem_rw   (mem_rw),
        .addr     (addr),
        .mmio_hit (mmio_hit),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .halt_req (halt_req)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: window contents as plain variables and a byte queue.
    logic [7:0]  q[$];
    logic [63:0] m_scr;
    logic [63:0] m_cyc;
    bit          m_ovf;
    bit          m_halt;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_scr  = '0;
        m_cyc  = '0;
        m_ovf  = 1'b0;
        m_halt = 1'b0;
    endfunction

    function automatic logic [63:0] model_read(input logic [2:0] off);
        logic [63:0] n;
        logic [63:0] v;
        n = 64'(q.size());
        case (off)
`ifdef MMIO_CYCLE_CNT_EN
            3'd0: v = m_cyc;
`else
            3'd0: v = 64'd0;
`endif
            3'd1: v = m_scr;
            3'd2: v = n;
            3'd3: v = (n << 8) | (m_ovf ? 64'd4 : 64'd0) |
                      ((n == 64'(DEPTH)) ? 64'd2 : 64'd0) | ((n == 0) ? 64'd1 : 64'd0);
            3'd4: v = {63'd0, m_halt};
            default: v = 64'd0;
        endcase
        return v;
    endfunction

    function automatic void model_edge(input bit st, input logic [2:0] off,
                                       input logic [63:0] d, input bit rdy);
        bit pop;
        bit full;
        pop  = (q.size() != 0) && rdy;
        full = (q.size() == DEPTH);
        if (pop) void'(q.pop_front());
        if (st) begin
            case (off)
                3'd1: m_scr = d;
                3'd2: if (!full || pop) q.push_back(d[7:0]); else m_ovf = 1'b1;
                3'd3: if (d[2]) m_ovf = 1'b0;
                3'd4: if (d != 0) m_halt = 1'b1;
                default: ;
            endcase
        end
        m_cyc = m_cyc + 64'd1;
    endfunction

    // One bus cycle, entered and left at a falling edge.
    task automatic step(input bit st, input logic [63:0] a, input logic [63:0] d,
                        input bit rdy, input bit chk, input logic [63:0] exp_rd,
                        input string nm);
        logic [63:0] m_exp;
        bit          hit;
        addr     = a;
        mem_rw   = st;
        drv      = st;
        wdat     = d;
        tx_ready = rdy;
        #1;
        hit = (a[63:6] == BASE[63:6]);
        check("mmio_hit", {63'd0, mmio_hit}, {63'd0, hit});
        check("tx_valid", {63'd0, tx_valid}, (q.size() != 0) ? 64'd1 : 64'd0);
        if (q.size() != 0) check("tx_data", {56'd0, tx_data}, {56'd0, q[0]});
        check("halt_req", {63'd0, halt_req}, {63'd0, m_halt});
        if (!st) begin
            m_exp = hit ? model_read(a[5:3]) : BUS_FREE;
            check("load_data", mem_data, m_exp);
            if (chk) check(nm, mem_data, exp_rd);
        end
        @(posedge clk);
        model_edge(st && hit, a[5:3], d, rdy);
        @(negedge clk);
    endtask

    task automatic probe(input logic [63:0] a, input logic [63:0] exp, input string nm);
        addr   = a;
        mem_rw = 1'b0;
        drv    = 1'b0;
        #1;
        check(nm, mem_data, exp);
    endtask

    typedef struct {
        bit          st;
        logic [2:0]  off;
        logic [63:0] d;
        bit          rdy;
        bit          chk;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[17];

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t exceeded bound", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra;
        logic [63:0] rdv;
        logic [2:0]  roff;
        int          r;
        bit          rrdy;

        tbl[0]  = '{1'b1, 3'd1, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 64'd0};
        tbl[1]  = '{1'b0, 3'd1, 64'd0, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567};
        tbl[2]  = '{1'b0, 3'd7, 64'd0, 1'b0, 1'b1, 64'd0};
        tbl[3]  = '{1'b0, 3'd5, 64'd0, 1'b0, 1'b1, 64'd0};
        tbl[4]  = '{1'b1, 3'd5, 64'hFFFF_0000_FFFF_0000, 1'b0, 1'b0, 64'd0};
        tbl[5]  = '{1'b0, 3'd5, 64'd0, 1'b0, 1'b1, 64'd0};
        tbl[6]  = '{1'b0, 3'd4, 64'd0, 1'b0, 1'b1, 64'd0};
        tbl[7]  = '{1'b1, 3'd4, 64'd0, 1'b0, 1'b0, 64'd0};
        tbl[8]  = '{1'b0, 3'd4, 64'd0, 1'b0, 1'b1, 64'd0};
        tbl[9]  = '{1'b0, 3'd3, 64'd0, 1'b0, 1'b1, 64'h1};
        tbl[10] = '{1'b1, 3'd2, 64'h41, 1'b0, 1'b0, 64'd0};
        tbl[11] = '{1'b1, 3'd2, 64'h42, 1'b0, 1'b0, 64'd0};
        tbl[12] = '{1'b1, 3'd2, 64'h43, 1'b0, 1'b0, 64'd0};
        tbl[13] = '{1'b0, 3'd3, 64'd0, 1'b0, 1'b1, 64'h300};
        tbl[14] = '{1'b0, 3'd2, 64'd0, 1'b0, 1'b1, 64'd3};
        tbl[15] = '{1'b1, 3'd3, 64'h0, 1'b0, 1'b0, 64'd0};
        tbl[16] = '{1'b0, 3'd2, 64'd0, 1'b0, 1'b1, 64'd3};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("rst_tx_data", {56'd0, tx_data}, 64'd0);
        check("rst_halt", {63'd0, halt_req}, 64'd0);
        probe(BASE + 64'h08, 64'd0, "rst_scratch");
        probe(BASE + 64'h18, 64'd1, "rst_status");
        probe(BASE + 64'h00, 64'd0, "rst_cycle");
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // ---- idle 10 clocks, then CYCLE ----
        for (int i = 0; i < 10; i++) step(1'b0, BASE + 64'h30, 64'd0, 1'b0, 1'b0, 64'd0, "idle");
        step(1'b0, BASE, 64'd0, 1'b0, 1'b1, EXP10, "cycle_after_10");

        // ---- directed vectors ----
        for (int i = 0; i < 17; i++)
            step(tbl[i].st, BASE + {58'd0, tbl[i].off, 3'd0}, tbl[i].d, tbl[i].rdy,
                 tbl[i].chk, tbl[i].exp, $sformatf("vec%0d", i));

        // ---- bus release and decode boundaries ----
        addr   = BASE + 64'h08;
        mem_rw = 1'b1;
        drv    = 1'b0;
        #1;
        check("bus_free_on_store", mem_data, BUS_FREE);
        mem_rw = 1'b0;
        step(1'b0, BASE + 64'h48, 64'd0, 1'b0, 1'b1, BUS_FREE, "bus_free_nohit");
        step(1'b0, BASE + 64'h3F, 64'd0, 1'b0, 1'b1, 64'd0, "hit_top");
        step(1'b0, BASE + 64'h40, 64'd0, 1'b0, 1'b1, BUS_FREE, "miss_above");
        step(1'b0, BASE - 64'h1, 64'd0, 1'b0, 1'b1, BUS_FREE, "miss_below");

        // ---- drain 0x41,0x42,0x43 in order ----
        for (int i = 0; i < 3; i++) begin
            check($sformatf("drain_valid%0d", i), {63'd0, tx_valid}, 64'd1);
            check($sformatf("drain_byte%0d", i), {56'd0, tx_data}, 64'h41 + 64'(i));
            step(1'b0, BASE + 64'h30, 64'd0, 1'b1, 1'b0, 64'd0, "drain");
        end
        check("drain_done_valid", {63'd0, tx_valid}, 64'd0);
        step(1'b0, BASE + 64'h18, 64'd0, 1'b0, 1'b1, 64'h1, "drain_empty");

        // ---- overflow ----
        for (int i = 0; i <= DEPTH; i++)
            step(1'b1, BASE + 64'h10, 64'h10 + 64'(i), 1'b0, 1'b0, 64'd0, "fill");
        step(1'b0, BASE + 64'h18, 64'd0, 1'b0, 1'b1, (64'(DEPTH) << 8) | 64'h6, "full_ovf");
        step(1'b1, BASE + 64'h10, 64'h20, 1'b1, 1'b0, 64'd0, "push_pop_full");
        check("push_pop_head", {56'd0, tx_data}, 64'h11);
        step(1'b0, BASE + 64'h18, 64'd0, 1'b0, 1'b1, (64'(DEPTH) << 8) | 64'h6, "still_full");
        step(1'b1, BASE + 64'h18, 64'h4, 1'b0, 1'b0, 64'd0, "clr_ovf");
        step(1'b0, BASE + 64'h18, 64'd0, 1'b0, 1'b1, (64'(DEPTH) << 8) | 64'h2, "ovf_cleared");
        for (int i = 0; i < DEPTH; i++) step(1'b0, BASE + 64'h30, 64'd0, 1'b1, 1'b0, 64'd0, "drain2");
        step(1'b0, BASE + 64'h18, 64'd0, 1'b0, 1'b1, 64'h1, "drain2_empty");

        // ---- halt ----
        step(1'b1, BASE + 64'h20, 64'h1, 1'b0, 1'b0, 64'd0, "halt_set");
        check("halt_next_cycle", {63'd0, halt_req}, 64'd1);
        step(1'b1, BASE + 64'h20, 64'h0, 1'b0, 1'b0, 64'd0, "halt_w0a");
        step(1'b1, BASE + 64'h20, 64'h0, 1'b0, 1'b0, 64'd0, "halt_w0b");
        step(1'b0, BASE + 64'h20, 64'd0, 1'b0, 1'b1, 64'h1, "halt_sticky");

        // ---- asynchronous reset mid-transfer ----
        step(1'b1, BASE + 64'h10, 64'h55, 1'b0, 1'b0, 64'd0, "pre_rst_push");
        step(1'b1, BASE + 64'h10, 64'h66, 1'b0, 1'b0, 64'd0, "pre_rst_push");
        check("pre_rst_valid", {63'd0, tx_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_tx_valid", {63'd0, tx_valid}, 64'd0);
        check("arst_halt", {63'd0, halt_req}, 64'd0);
        probe(BASE + 64'h18, 64'd1, "arst_status");
        probe(BASE + 64'h08, 64'd0, "arst_scratch");
        probe(BASE + 64'h00, 64'd0, "arst_cycle");
        @(negedge clk);
        model_reset();
        rst = 1'b0;

        // ---- 100 clocks, then CYCLE ----
        for (int i = 0; i < 100; i++) step(1'b0, BASE + 64'h30, 64'd0, 1'b0, 1'b0, 64'd0, "idle");
        step(1'b0, BASE, 64'd0, 1'b0, 1'b1, EXP100, "cycle_after_100");

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 3000; i++) begin
            r    = int'($urandom_range(0, 9));
            roff = (r < 4) ? 3'd2 : 3'($urandom_range(0, 7));
            ra   = BASE + 64'({roff, 3'b000}) + 64'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) ra = {$urandom, $urandom};
            rdv  = {$urandom, $urandom};
            if (roff == 3'd4 && $urandom_range(0, 3) != 0) rdv = '0;
            rrdy = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
            step($urandom_range(0, 1) == 1, ra, rdv, rrdy, 1'b0, 64'd0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
